// File: rtl/ahb_sram_slave.sv
// AHB-lite single-port SRAM slave: sized 8/16/32-bit transfers, optional wait
// states, two-cycle ERROR response, registered read data with write-first forwarding.
module ahb_sram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_sel,
  input  logic        i_write,
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_trans,
  input  logic        i_ready_in,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready_out,
  output logic        o_resp
);

  localparam int          AW    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] BYTES = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t        r_state, w_next, w_acc_state;
  logic [31:0]   r_mem [DEPTH_WORDS];
  logic [31:0]   r_rdata;
  logic          r_write;
  logic [3:0]    r_be;
  logic [AW-1:0] r_idx;
  logic [3:0]    r_cnt;

  logic [31:0]   w_offset, w_rd_word;
  logic [AW-1:0] w_idx, w_rd_idx;
  logic [3:0]    w_be;
  logic          w_err, w_ready, w_accept, w_commit, w_load;

  assign w_offset = i_addr - BASE_ADDR;
  assign w_idx    = w_offset[AW+1:2];
  assign w_err    = (w_offset >= BYTES) || (i_size > 3'd2) ||
                    (i_size == 3'd1 && i_addr[0]) ||
                    (i_size == 3'd2 && i_addr[1:0] != 2'b00);

  assign w_ready  = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
  assign w_accept = i_sel && i_ready_in && (i_trans == 2'b10 || i_trans == 2'b11) && w_ready;
  assign w_commit = (r_state == S_DATA) && r_write;

  // A read leaving WAIT uses the latched index; otherwise it is being accepted now.
  assign w_rd_idx = (r_state == S_WAIT) ? r_idx : w_idx;
  assign w_load   = (w_accept && !w_err && !i_write && (WAIT_STATES == 0)) ||
                    ((r_state == S_WAIT) && (r_cnt <= 4'd1) && !r_write);

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_be = 4'b1111;
    case (i_size)
      3'd0:    w_be = 4'b0001 << i_addr[1:0];
      3'd1:    w_be = i_addr[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  always_comb begin
    w_acc_state = S_DATA;
    if (w_err)                 w_acc_state = S_ERR1;
    else if (WAIT_STATES != 0) w_acc_state = S_WAIT;

    w_next = r_state;
    case (r_state)
      S_WAIT:  if (r_cnt <= 4'd1) w_next = S_DATA;
      S_ERR1:  w_next = S_ERR2;
      default: w_next = w_accept ? w_acc_state : S_IDLE;
    endcase
  end

  // Write-first: a read accepted while a write to the same word commits sees the new bytes.
  always_comb begin
    w_rd_word = r_mem[w_rd_idx];
    if (w_commit && (r_idx == w_rd_idx)) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) w_rd_word[8*b +: 8] = i_wdata[8*b +: 8];
      end
    end
  end

  // NOTE: the array has no reset branch on purpose; clearing it would turn the
  // SRAM into flops. Sequential state always uses non-blocking assignments.
  always_ff @(posedge i_clk) begin
    if (!i_rst && w_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (r_be[b]) r_mem[r_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_rdata <= 32'h0;
      r_write <= 1'b0;
      r_be    <= 4'h0;
      r_idx   <= '0;
      r_cnt   <= 4'h0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write <= i_write;
        r_be    <= w_be;
        r_idx   <= w_idx;
        r_cnt   <= WS;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_load) r_rdata <= w_rd_word;
    end
  end

  assign o_rdata     = r_rdata;
  assign o_ready_out = w_ready;
  assign o_resp      = (r_state == S_ERR1) || (r_state == S_ERR2);

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: a zero-wait and a two-wait instance, each checked every
// cycle against a transaction-level model (phase queue + byte-valid memory image).
module tb_ahb_sram_slave;

  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_1000;
  localparam logic [1:0]  NS    = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel [2], write [2], ready_in [2], ready_out [2], resp [2];
  logic [31:0] addr [2], wdata [2], rdata [2];
  logic [2:0]  size [2];
  logic [1:0]  trans [2];

  ahb_sram_slave #(.BASE_ADDR(BASE0), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_ws0 (
    .i_clk(clk), .i_rst(rst), .i_sel(sel[0]), .i_write(write[0]), .i_addr(addr[0]),
    .i_size(size[0]), .i_trans(trans[0]), .i_ready_in(ready_in[0]), .i_wdata(wdata[0]),
    .o_rdata(rdata[0]), .o_ready_out(ready_out[0]), .o_resp(resp[0]));

  ahb_sram_slave #(.BASE_ADDR(BASE1), .DEPTH_WORDS(DEPTH), .WAIT_STATES(2)) u_ws2 (
    .i_clk(clk), .i_rst(rst), .i_sel(sel[1]), .i_write(write[1]), .i_addr(addr[1]),
    .i_size(size[1]), .i_trans(trans[1]), .i_ready_in(ready_in[1]), .i_wdata(wdata[1]),
    .o_rdata(rdata[1]), .o_ready_out(ready_out[1]), .o_resp(resp[1]));

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         ready;
    bit         resp;
    bit         rd;
    bit         wr;
    int         idx;
    logic [3:0] be;
  } ph_t;

  ph_t         q [2][$];
  ph_t         cur [2];
  logic [31:0] mm [2][DEPTH];
  logic [3:0]  mv [2][DEPTH];
  logic [31:0] rexp [2];
  bit          rknown [2];
  bit          started = 1'b0;

  function automatic ph_t mk_ph(bit rdy, bit rsp);
    ph_t p;
    p.ready = rdy; p.resp = rsp; p.rd = 1'b0; p.wr = 1'b0; p.idx = 0; p.be = 4'h0;
    return p;
  endfunction

  function automatic logic [31:0] base_of(int k);
    return (k == 0) ? BASE0 : BASE1;
  endfunction

  function automatic int ws_of(int k);
    return (k == 0) ? 0 : 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Schedule the output phases of one accepted transfer, straight from the bus rules.
  task automatic push_transfer(input int k);
    logic [31:0] off;
    bit          err;
    ph_t         p;
    off = addr[k] - base_of(k);
    err = (off >= 32'(4 * DEPTH)) || (size[k] > 3'd2) ||
          (size[k] == 3'd1 && addr[k][0]) || (size[k] == 3'd2 && addr[k][1:0] != 2'b00);
    if (err) begin
      q[k].push_back(mk_ph(1'b0, 1'b1));
      q[k].push_back(mk_ph(1'b1, 1'b1));
    end else begin
      for (int i = 0; i < ws_of(k); i++) q[k].push_back(mk_ph(1'b0, 1'b0));
      p     = mk_ph(1'b1, 1'b0);
      p.rd  = !write[k];
      p.wr  = write[k];
      p.idx = int'(off / 4);
      case (size[k])
        3'd0:    p.be = 4'b0001 << addr[k][1:0];
        3'd1:    p.be = 4'b0011 << (2 * addr[k][1]);
        default: p.be = 4'b1111;
      endcase
      q[k].push_back(p);
    end
  endtask

  // Model advances on the same edge as the DUT, reading only bench-driven inputs.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        q[k].delete();
        cur[k]    = mk_ph(1'b1, 1'b0);
        rexp[k]   = 32'h0;
        rknown[k] = 1'b1;
      end else begin
        if (cur[k].wr) begin
          for (int b = 0; b < 4; b++) begin
            if (cur[k].be[b]) begin
              mm[k][cur[k].idx][8*b +: 8] = wdata[k][8*b +: 8];
              mv[k][cur[k].idx][b]        = 1'b1;
            end
          end
        end
        if (sel[k] && ready_in[k] && trans[k] >= 2'd2 && cur[k].ready) push_transfer(k);
        cur[k] = (q[k].size() > 0) ? q[k].pop_front() : mk_ph(1'b1, 1'b0);
        if (cur[k].rd) begin
          rexp[k]   = mm[k][cur[k].idx];
          rknown[k] = (mv[k][cur[k].idx] == 4'hF);
        end
      end
    end
    if (rst) started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("ready%0d", k), 32'(ready_out[k]), 32'(cur[k].ready));
        check($sformatf("resp%0d", k), 32'(resp[k]), 32'(cur[k].resp));
        if (rknown[k]) check($sformatf("rdata%0d", k), rdata[k], rexp[k]);
      end
    end
  end

  task automatic set_req(input int k, input bit s, input logic [1:0] tr, input bit w,
                         input logic [31:0] a, input logic [2:0] sz);
    sel[k] = s; trans[k] = tr; write[k] = w; addr[k] = a; size[k] = sz; ready_in[k] = 1'b1;
  endtask

  task automatic go_idle(input int k);
    set_req(k, 1'b0, 2'b00, 1'b0, base_of(k), 3'd2);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      go_idle(k);
      wdata[k]  = 32'h0;
      cur[k]    = mk_ph(1'b1, 1'b0);
      rexp[k]   = 32'h0;
      rknown[k] = 1'b0;
      for (int i = 0; i < DEPTH; i++) mv[k][i] = 4'h0;
    end
    tick(); tick();
    rst = 1'b0;
    check("rst_rdy", 32'(ready_out[0]), 32'd1);
    check("rst_rdata", rdata[0], 32'h0);

    // Zero-wait write then pipelined read of the same word.
    set_req(0, 1'b1, NS, 1'b1, 32'h10, 3'd2); tick();
    check("t1_wr_rdy", 32'(ready_out[0]), 32'd1);
    check("t1_wr_resp", 32'(resp[0]), 32'd0);
    set_req(0, 1'b1, NS, 1'b0, 32'h10, 3'd2); wdata[0] = 32'hDEADBEEF; tick();
    go_idle(0);
    check("t1_rd_data", rdata[0], 32'hDEADBEEF);
    check("t1_model", rexp[0], 32'hDEADBEEF);
    tick();

    // Byte write into the top lane.
    set_req(0, 1'b1, NS, 1'b1, 32'h10, 3'd2); tick();
    set_req(0, 1'b1, NS, 1'b1, 32'h13, 3'd0); wdata[0] = 32'h11223344; tick();
    set_req(0, 1'b1, NS, 1'b0, 32'h10, 3'd2); wdata[0] = 32'hA5000000; tick();
    go_idle(0);
    check("t2_rd_data", rdata[0], 32'hA5223344);
    tick();

    // Misaligned and out-of-range transfers take the two-cycle error path.
    set_req(0, 1'b1, NS, 1'b1, 32'h0, 3'd2); tick();
    set_req(0, 1'b1, NS, 1'b0, 32'h2, 3'd2); wdata[0] = 32'h01234567; tick();
    go_idle(0);
    check("t3_err1_rdy", 32'(ready_out[0]), 32'd0);
    check("t3_err1_resp", 32'(resp[0]), 32'd1);
    check("t3_rdata_hold", rdata[0], 32'hA5223344);
    tick();
    check("t3_err2_rdy", 32'(ready_out[0]), 32'd1);
    check("t3_err2_resp", 32'(resp[0]), 32'd1);
    set_req(0, 1'b1, NS, 1'b0, 32'h40, 3'd2); tick();
    go_idle(0);
    check("t3_oor_err1", {30'd0, ready_out[0], resp[0]}, 32'b01);
    tick();
    check("t3_oor_err2", {30'd0, ready_out[0], resp[0]}, 32'b11);
    set_req(0, 1'b1, NS, 1'b1, 32'h2, 3'd2); tick();
    go_idle(0); wdata[0] = 32'hFFFFFFFF; tick();
    set_req(0, 1'b1, NS, 1'b0, 32'h0, 3'd2); tick();
    go_idle(0);
    check("t3_mem_kept", rdata[0], 32'h01234567);
    tick();

    // Two wait states, with a back-to-back read offered in the data cycle.
    set_req(1, 1'b1, NS, 1'b1, BASE1 + 32'h8, 3'd2); wdata[1] = 32'hCAFEF00D; tick();
    go_idle(1);
    check("t4_w_wait1", 32'(ready_out[1]), 32'd0); tick();
    check("t4_w_wait2", 32'(ready_out[1]), 32'd0); tick();
    check("t4_w_data", 32'(ready_out[1]), 32'd1);
    set_req(1, 1'b1, NS, 1'b0, BASE1 + 32'h8, 3'd2); tick();
    go_idle(1);
    check("t4_r_wait1", 32'(ready_out[1]), 32'd0); tick();
    check("t4_r_wait2", 32'(ready_out[1]), 32'd0); tick();
    check("t4_r_data", rdata[1], 32'hCAFEF00D);
    set_req(1, 1'b1, NS, 1'b0, BASE1 + 32'h8, 3'd2); tick();
    go_idle(1);
    check("t4_b2b_taken", 32'(ready_out[1]), 32'd0); tick(); tick();
    check("t4_b2b_rdy", 32'(ready_out[1]), 32'd1);
    check("t4_b2b_data", rdata[1], 32'hCAFEF00D);

    // Reset during the wait of a write drops it.
    set_req(1, 1'b1, NS, 1'b1, BASE1 + 32'h8, 3'd2); wdata[1] = 32'h12345678; tick();
    go_idle(1);
    check("t6_in_wait", 32'(ready_out[1]), 32'd0);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_rst_rdy", {30'd0, ready_out[1], resp[1]}, 32'b10);
    check("t6_rst_rdata", rdata[1], 32'h0);
    set_req(1, 1'b1, NS, 1'b0, BASE1 + 32'h8, 3'd2); tick();
    go_idle(1); tick(); tick();
    check("t6_old_data", rdata[1], 32'hCAFEF00D);
    set_req(1, 1'b1, 2'b00, 1'b0, BASE1 + 32'h8, 3'd2); tick();
    check("t6_idle_ign", 32'(ready_out[1]), 32'd1);
    set_req(1, 1'b1, 2'b01, 1'b0, BASE1 + 32'h8, 3'd2); tick();
    check("t6_busy_ign", 32'(ready_out[1]), 32'd1);
    go_idle(1); tick();

    // Randomised traffic, mostly in range, with some bad sizes, far addresses and resets.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        sel[k]      = ($urandom % 4) != 0;
        trans[k]    = 2'($urandom % 4);
        write[k]    = 1'($urandom % 2);
        size[k]     = (($urandom % 8) == 0) ? 3'($urandom % 8) : 3'($urandom % 3);
        addr[k]     = (($urandom % 12) == 0) ? $urandom
                                             : base_of(k) + ($urandom % (4 * DEPTH + 8));
        ready_in[k] = ($urandom % 8) != 0;
        wdata[k]    = $urandom;
      end
      rst = (($urandom % 300) == 0);
      tick();
    end
    rst = 1'b0;
    go_idle(0); go_idle(1);
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
